// File: rtl/tis_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// tis_ctrl_pkg
// Shared encodings for the TIS-100 node execution controller:
//   - instruction type codes (instrType)
//   - source/destination selector codes (src_sel / dst_sel)
//   - controller FSM states
//   - operand-select, ALU and jump-condition encodings
//   - decoded control bundle carried from DECODE to COMMIT
//   - port_mask(): selector -> neighbour-port request mask
// ----------------------------------------------------------------------------
package tis_ctrl_pkg;

   localparam int unsigned NUM_PORTS_C = 4;

   typedef enum logic [4:0] {
      INSTR_NOP = 5'd0,
      INSTR_MOV = 5'd1,
      INSTR_SWP = 5'd2,
      INSTR_SAV = 5'd3,
      INSTR_ADD = 5'd4,
      INSTR_SUB = 5'd5,
      INSTR_NEG = 5'd6,
      INSTR_JMP = 5'd7,
      INSTR_JEZ = 5'd8,
      INSTR_JNZ = 5'd9,
      INSTR_JGZ = 5'd10,
      INSTR_JLZ = 5'd11,
      INSTR_JRO = 5'd12,
      INSTR_HCF = 5'd13
   } instr_e;

   typedef enum logic [2:0] {
      SEL_NIL   = 3'd0,
      SEL_ACC   = 3'd1,
      SEL_IMM   = 3'd2,
      SEL_UP    = 3'd3,
      SEL_RIGHT = 3'd4,
      SEL_DOWN  = 3'd5,
      SEL_LEFT  = 3'd6,
      SEL_ANY   = 3'd7
   } sel_e;

   typedef enum logic [1:0] {
      ST_DECODE  = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2,
      ST_COMMIT  = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      OPA_ACC  = 2'b00,
      OPA_IMM  = 2'b01,
      OPA_PORT = 2'b10,
      OPA_NIL  = 2'b11
   } opa_e;

   typedef enum logic [1:0] {
      ALU_PASS = 2'b00,
      ALU_ADD  = 2'b01,
      ALU_SUB  = 2'b10,
      ALU_NEG  = 2'b11
   } alu_e;

   typedef enum logic [1:0] {
      JC_EZ = 2'b00,
      JC_NZ = 2'b01,
      JC_GZ = 2'b10,
      JC_LZ = 2'b11
   } jcond_e;

   // Everything the instruction needs, captured once in DECODE.
   // rd_mask/wr_mask are the neighbour ports the instruction may read from
   // or write to (all four for ANY, none for non-port operands).
   typedef struct packed {
      logic                   swp_active;
      opa_e                   swpin_a;
      logic                   swpin_b;
      logic                   en_bak;
      alu_e                   alu;
      logic                   jmp;
      jcond_e                 jcond;
      logic [NUM_PORTS_C-1:0] rd_mask;
      logic [NUM_PORTS_C-1:0] wr_mask;
   } ctrl_t;

   function automatic logic [NUM_PORTS_C-1:0] port_mask(input logic [2:0] sel);
      logic [NUM_PORTS_C-1:0] m;
      m = '0;
      case (sel)
         SEL_UP:    m = 4'b0001;
         SEL_RIGHT: m = 4'b0010;
         SEL_DOWN:  m = 4'b0100;
         SEL_LEFT:  m = 4'b1000;
         SEL_ANY:   m = 4'b1111;
         default:   m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/port_prio_arb.sv
// ----------------------------------------------------------------------------
// port_prio_arb
// Fixed-priority arbiter over the four neighbour ports, UP (index 0) highest.
// Used both for picking the read source and the write destination.
// Ports:
//   req_i [3:0]  per-port request
//   gnt_o [3:0]  one-hot grant (zero when no request)
//   idx_o [1:0]  index of the granted port (0 when no request)
//   any_o        at least one request present
// ----------------------------------------------------------------------------
module port_prio_arb
   import tis_ctrl_pkg::*;
(
   input  logic [NUM_PORTS_C-1:0] req_i,
   output logic [NUM_PORTS_C-1:0] gnt_o,
   output logic [1:0]             idx_o,
   output logic                   any_o
);

   always_comb begin
      gnt_o = '0;
      idx_o = 2'd0;
      any_o = |req_i;
      if (req_i[0]) begin
         gnt_o = 4'b0001;
         idx_o = 2'd0;
      end else if (req_i[1]) begin
         gnt_o = 4'b0010;
         idx_o = 2'd1;
      end else if (req_i[2]) begin
         gnt_o = 4'b0100;
         idx_o = 2'd2;
      end else if (req_i[3]) begin
         gnt_o = 4'b1000;
         idx_o = 2'd3;
      end
   end

endmodule

// File: rtl/node_exec_ctrl.sv
// ----------------------------------------------------------------------------
// node_exec_ctrl
// Per-node sequencer of the TIS-100 execution path. Decodes the instruction
// into data_path/jmp_path controls, blocks on neighbour reads/writes and
// issues a one-cycle commit strobe.
//
// Optional feature: define NODE_EXEC_CTRL_DEADLOCK_EN to enable the deadlock
// watchdog (8-bit wait-run counter, sticky `deadlock` flag). Without it
// `deadlock` is tied to 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run                   permit starting the next instruction
//   instrType/src_sel/dst_sel  current instruction
//   port_in_valid/port_in_ack     neighbour read handshake
//   port_out_valid/port_out_ready neighbour write handshake
//   port_sel              index of the port won by the current read/write
//   SwpActiveReg, SwpinA, SwpinB, enBak, ALUdesk  data_path controls
//   jmpInstr, jmpCond     jmp_path controls
//   exec_en               one-cycle commit strobe
//   stall, stall_cnt      wait indication and saturating stall-cycle count
//   deadlock              sticky deadlock flag
//   dbg_state_o           current FSM state (tis_ctrl_pkg::state_e)
//
// Handshakes: a transfer happens in a cycle where both sides agree. For reads
// the neighbour holds port_in_valid; we answer with a one-hot port_in_ack in
// the same cycle (Mealy) and the data is taken on that edge. For writes we
// hold port_out_valid until some selected neighbour raises port_out_ready;
// the lowest-index ready port takes the word and valid drops the next cycle.
// NUM_PORTS must stay 4 (fixed UP/RIGHT/DOWN/LEFT topology).
// ----------------------------------------------------------------------------
module node_exec_ctrl
   import tis_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PORTS = 4,
   parameter int unsigned STALL_W   = 16
`ifdef NODE_EXEC_CTRL_DEADLOCK_EN
   ,
   // Legal range 1..255 (the wait-run counter is 8 bits wide).
   parameter int unsigned DEADLOCK_CYCLES = 255
`endif
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 run,
   input  logic [4:0]           instrType,
   input  logic [2:0]           src_sel,
   input  logic [2:0]           dst_sel,
   input  logic [NUM_PORTS-1:0] port_in_valid,
   output logic [NUM_PORTS-1:0] port_in_ack,
   input  logic [NUM_PORTS-1:0] port_out_ready,
   output logic [NUM_PORTS-1:0] port_out_valid,
   output logic [1:0]           port_sel,
   output logic                 SwpActiveReg,
   output logic [1:0]           SwpinA,
   output logic                 SwpinB,
   output logic                 enBak,
   output logic [1:0]           ALUdesk,
   output logic                 jmpInstr,
   output logic [1:0]           jmpCond,
   output logic                 exec_en,
   output logic                 stall,
   output logic [STALL_W-1:0]   stall_cnt,
   output logic                 deadlock,
   output logic [1:0]           dbg_state_o
);

   state_e               state_q, state_d;
   ctrl_t                ctrl_q, ctrl_d, dec;
   logic [1:0]           sel_q, sel_d, sel_out;
   logic [NUM_PORTS-1:0] ack_c, oval_c;
   logic                 exec_c;
   logic                 reads_src;
   logic                 in_wait;
   logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
   logic [NUM_PORTS-1:0] arb_req, arb_gnt;
   logic [1:0]           arb_idx;
   logic                 arb_any;

   // ---------------- instruction decode (combinational) ----------------
   always_comb begin : decode_c
      dec       = '0;
      reads_src = 1'b0;
      case (instrType)
         INSTR_MOV: begin
            reads_src   = 1'b1;
            dec.wr_mask = port_mask(dst_sel);   // IMM destination maps to no port
         end
         INSTR_SWP: begin
            dec.swpin_b    = 1'b1;
            dec.swp_active = 1'b1;
            dec.en_bak     = 1'b1;
         end
         INSTR_SAV: begin
            dec.swpin_b = 1'b1;
            dec.en_bak  = 1'b1;
         end
         INSTR_ADD: begin
            reads_src = 1'b1;
            dec.alu   = ALU_ADD;
         end
         INSTR_SUB: begin
            reads_src = 1'b1;
            dec.alu   = ALU_SUB;
         end
         INSTR_NEG: dec.alu = ALU_NEG;
         INSTR_JMP: dec.jmp = 1'b1;
         INSTR_JEZ: begin
            dec.jmp   = 1'b1;
            dec.jcond = JC_EZ;
         end
         INSTR_JNZ: begin
            dec.jmp   = 1'b1;
            dec.jcond = JC_NZ;
         end
         INSTR_JGZ: begin
            dec.jmp   = 1'b1;
            dec.jcond = JC_GZ;
         end
         INSTR_JLZ: begin
            dec.jmp   = 1'b1;
            dec.jcond = JC_LZ;
         end
         INSTR_JRO: begin
            reads_src = 1'b1;
            dec.jmp   = 1'b1;
         end
         default: ;   // NOP, HCF and undefined codes do nothing
      endcase
      // Only source-consuming instructions select an operand or read a port.
      if (reads_src) begin
         dec.rd_mask = port_mask(src_sel);
         case (src_sel)
            SEL_NIL: dec.swpin_a = OPA_NIL;
            SEL_ACC: dec.swpin_a = OPA_ACC;
            SEL_IMM: dec.swpin_a = OPA_IMM;
            default: dec.swpin_a = OPA_PORT;
         endcase
      end
   end

   // ---------------- port arbitration ----------------
   // Only one of read/write is ever in flight, so one arbiter serves both.
   always_comb begin
      arb_req = '0;
      if (state_q == ST_RD_WAIT) begin
         arb_req = port_in_valid & ctrl_q.rd_mask;
      end else if (state_q == ST_WR_WAIT) begin
         arb_req = port_out_ready & ctrl_q.wr_mask;
      end
   end

   port_prio_arb u_arb (
      .req_i (arb_req),
      .gnt_o (arb_gnt),
      .idx_o (arb_idx),
      .any_o (arb_any)
   );

   // ---------------- FSM next state / outputs ----------------
   always_comb begin : fsm_c
      state_d = state_q;
      ctrl_d  = ctrl_q;
      sel_d   = sel_q;
      sel_out = sel_q;
      ack_c   = '0;
      oval_c  = '0;
      exec_c  = 1'b0;
      case (state_q)
         ST_DECODE: begin
            if (run) begin
               ctrl_d = dec;
               if (|dec.rd_mask) begin
                  state_d = ST_RD_WAIT;
               end else if (|dec.wr_mask) begin
                  state_d = ST_WR_WAIT;
               end else begin
                  state_d = ST_COMMIT;
               end
            end
         end
         ST_RD_WAIT: begin
            if (arb_any) begin
               ack_c   = arb_gnt;
               sel_out = arb_idx;
               sel_d   = arb_idx;
               state_d = (|ctrl_q.wr_mask) ? ST_WR_WAIT : ST_COMMIT;
            end
         end
         ST_WR_WAIT: begin
            oval_c = ctrl_q.wr_mask;
            if (arb_any) begin
               sel_out = arb_idx;
               sel_d   = arb_idx;
               state_d = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            exec_c  = 1'b1;
            state_d = ST_DECODE;
         end
         default: state_d = ST_DECODE;
      endcase
   end

   assign in_wait = (state_q == ST_RD_WAIT) || (state_q == ST_WR_WAIT);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (in_wait && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_DECODE;
         ctrl_q      <= '0;
         sel_q       <= 2'd0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         ctrl_q      <= ctrl_d;
         sel_q       <= sel_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // ---------------- deadlock watchdog ----------------
`ifdef NODE_EXEC_CTRL_DEADLOCK_EN
   localparam logic [7:0] DL_LIMIT = 8'(DEADLOCK_CYCLES);

   logic [7:0] wait_run_q, wait_run_d;
   logic       deadlock_q, deadlock_d;

   // Counts consecutive cycles spent in the same wait state; any exit
   // (RD->WR, ->COMMIT) restarts it. Saturates so it never wraps past the limit.
   always_comb begin
      wait_run_d = '0;
      if (in_wait && (state_d == state_q)) begin
         wait_run_d = (wait_run_q == 8'hFF) ? wait_run_q : wait_run_q + 8'd1;
      end
      deadlock_d = deadlock_q | (wait_run_d == DL_LIMIT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_run_q <= '0;
         deadlock_q <= 1'b0;
      end else begin
         wait_run_q <= wait_run_d;
         deadlock_q <= deadlock_d;
      end
   end

   assign deadlock = deadlock_q;
`else
   assign deadlock = 1'b0;
`endif

   // ---------------- outputs ----------------
   // Handshake and strobe outputs are killed combinationally by reset so a
   // reset mid-wait drops them in the same cycle.
   assign port_in_ack    = reset ? '0 : ack_c;
   assign port_out_valid = reset ? '0 : oval_c;
   assign exec_en        = ~reset & exec_c;
   assign stall          = ~reset & in_wait;
   assign port_sel       = reset ? sel_q : sel_out;

   assign SwpActiveReg = ctrl_q.swp_active;
   assign SwpinA       = ctrl_q.swpin_a;
   assign SwpinB       = ctrl_q.swpin_b;
   assign enBak        = ctrl_q.en_bak;
   assign ALUdesk      = ctrl_q.alu;
   assign jmpInstr     = ctrl_q.jmp;
   assign jmpCond      = ctrl_q.jcond;
   assign stall_cnt    = stall_cnt_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_node_exec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_node_exec_ctrl
// Directed scenarios with literal expectations, then randomized instructions
// and neighbour behaviour. A transaction-level model keeps, per instruction,
// a queue of remaining steps (read, write, commit) and derives the expected
// outputs of every cycle from the head step.
// ----------------------------------------------------------------------------
module tb_node_exec_ctrl;

   localparam int STEP_RD = 1;
   localparam int STEP_WR = 2;
   localparam int STEP_CM = 3;
   localparam int DL_CYCLES = 255;
`ifdef NODE_EXEC_CTRL_DEADLOCK_EN
   localparam int DL_EN = 1;
`else
   localparam int DL_EN = 0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic       clk = 1'b0;
   logic       reset, run;
   logic [4:0] instr;
   logic [2:0] src, dst;
   logic [3:0] in_valid, in_ack, out_ready, out_valid;
   logic [1:0] port_sel, swpin_a, alu, jcond, dbg_state;
   logic       swp_active, swpin_b, en_bak, jmp, exec_en, stall, deadlock;
   logic [15:0] stall_cnt;

   always #5 clk = ~clk;

   node_exec_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .instrType      (instr),
      .src_sel        (src),
      .dst_sel        (dst),
      .port_in_valid  (in_valid),
      .port_in_ack    (in_ack),
      .port_out_ready (out_ready),
      .port_out_valid (out_valid),
      .port_sel       (port_sel),
      .SwpActiveReg   (swp_active),
      .SwpinA         (swpin_a),
      .SwpinB         (swpin_b),
      .enBak          (en_bak),
      .ALUdesk        (alu),
      .jmpInstr       (jmp),
      .jmpCond        (jcond),
      .exec_en        (exec_en),
      .stall          (stall),
      .stall_cnt      (stall_cnt),
      .deadlock       (deadlock),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Remaining steps of the instruction in flight (empty = waiting to decode).
   logic [1:0] exp_q[$];
   int  m_rd_mask, m_wr_mask, m_sel, m_stall, m_run, m_dl;
   int  m_sar, m_swa, m_swb, m_enb, m_alu, m_ji, m_jc;
   bit  model_on = 1'b0;

   function automatic int port_bits(input int s);
      if (s == 7) return 15;
      if (s >= 3) return 1 << (s - 3);
      return 0;
   endfunction

   task automatic model_load(input int t, input int s, input int d);
      bit rd_src;
      rd_src    = (t == 1) || (t == 4) || (t == 5) || (t == 12);
      m_sar     = (t == 2) ? 1 : 0;
      m_swb     = (t == 2 || t == 3) ? 1 : 0;
      m_enb     = m_swb;
      m_swa     = !rd_src ? 0 : (s == 0) ? 3 : (s == 1) ? 0 : (s == 2) ? 1 : 2;
      m_alu     = (t == 4) ? 1 : (t == 5) ? 2 : (t == 6) ? 3 : 0;
      m_ji      = (t >= 7 && t <= 12) ? 1 : 0;
      m_jc      = (t >= 8 && t <= 11) ? t - 8 : 0;
      m_rd_mask = rd_src ? port_bits(s) : 0;
      m_wr_mask = (t == 1) ? port_bits(d) : 0;
      if (m_rd_mask != 0) exp_q.push_back(2'(STEP_RD));
      if (m_wr_mask != 0) exp_q.push_back(2'(STEP_WR));
      exp_q.push_back(2'(STEP_CM));
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_rd_mask = 0; m_wr_mask = 0; m_sel = 0; m_stall = 0; m_run = 0; m_dl = 0;
      m_sar = 0; m_swa = 0; m_swb = 0; m_enb = 0; m_alu = 0; m_ji = 0; m_jc = 0;
   endtask

   // Compare this cycle's outputs, then advance the model across the edge.
   task automatic model_step();
      int  head, req, win, e_ack, e_val, e_exec, e_stall, e_sel;
      bit  done;
      if (reset) begin
         chk("rst_ack", 32'(in_ack), 0);
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_exec_en", 32'(exec_en), 0);
         chk("rst_stall", 32'(stall), 0);
         model_reset();
         model_on = 1'b1;
         return;
      end
      if (!model_on) return;
      head = (exp_q.size() > 0) ? int'(exp_q[0]) : 0;
      e_ack = 0; e_val = 0; e_exec = 0; e_stall = 0; e_sel = m_sel;
      done = 1'b0; win = -1; req = 0;
      if (head == STEP_RD) req = int'(in_valid) & m_rd_mask;
      if (head == STEP_WR) begin
         req   = int'(out_ready) & m_wr_mask;
         e_val = m_wr_mask;
      end
      if (head == STEP_RD || head == STEP_WR) begin
         e_stall = 1;
         for (int i = 0; i < 4; i++) if (win < 0 && ((req >> i) & 1) == 1) win = i;
         if (win >= 0) begin
            done  = 1'b1;
            e_sel = win;
            if (head == STEP_RD) e_ack = 1 << win;
         end
      end
      if (head == STEP_CM) begin
         e_exec = 1;
         done   = 1'b1;
      end
      chk("m_ack", 32'(in_ack), e_ack);
      chk("m_out_valid", 32'(out_valid), e_val);
      chk("m_exec_en", 32'(exec_en), e_exec);
      chk("m_stall", 32'(stall), e_stall);
      chk("m_port_sel", 32'(port_sel), e_sel);
      chk("m_stall_cnt", 32'(stall_cnt), m_stall);
      chk("m_deadlock", 32'(deadlock), (DL_EN != 0) ? m_dl : 0);
      chk("m_SwpActiveReg", 32'(swp_active), m_sar);
      chk("m_SwpinA", 32'(swpin_a), m_swa);
      chk("m_SwpinB", 32'(swpin_b), m_swb);
      chk("m_enBak", 32'(en_bak), m_enb);
      chk("m_ALUdesk", 32'(alu), m_alu);
      chk("m_jmpInstr", 32'(jmp), m_ji);
      chk("m_jmpCond", 32'(jcond), m_jc);
      if (e_stall != 0) begin
         if (m_stall < 65535) m_stall++;
         if (done) m_run = 0;
         else begin
            m_run = (m_run < 255) ? m_run + 1 : 255;
            if (m_run == DL_CYCLES) m_dl = 1;
         end
      end
      if (done) begin
         void'(exp_q.pop_front());
         m_sel = e_sel;
      end
      if (head == 0 && run) model_load(int'(instr), int'(src), int'(dst));
   endtask

   // ---------------- driver tasks ----------------
   task automatic settle();
      @(negedge clk);
      model_step();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc();
      settle();
      adv();
   endtask

   task automatic issue(input int t, input int s, input int d);
      instr = 5'(t); src = 3'(s); dst = 3'(d); run = 1'b1;
      cyc();
      run = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; run = 1'b0; instr = '0; src = '0; dst = '0;
      in_valid = '0; out_ready = '0;
      repeat (3) cyc();
      reset = 1'b0;
      settle();
      chk("post_reset_stall_cnt", 32'(stall_cnt), 0);
      chk("post_reset_ALUdesk", 32'(alu), 0);
      chk("post_reset_exec_en", 32'(exec_en), 0);
      chk("post_reset_deadlock", 32'(deadlock), 0);
      adv();

      // ADD IMM: decode cycle, then commit on the second cycle.
      instr = 5'd4; src = 3'd2; dst = 3'd0; run = 1'b1;
      settle();
      chk("t1_decode_exec_en", 32'(exec_en), 0);
      adv();
      run = 1'b0;
      settle();
      chk("t1_exec_en", 32'(exec_en), 1);
      chk("t1_ALUdesk", 32'(alu), 1);
      chk("t1_SwpinA", 32'(swpin_a), 1);
      chk("t1_stall", 32'(stall), 0);
      adv();

      // MOV UP->ACC, UP valid only on the fifth wait cycle.
      issue(1, 3, 1);
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("t2_wait_stall", 32'(stall), 1);
         chk("t2_wait_ack", 32'(in_ack), 0);
         adv();
      end
      in_valid = 4'b0001;
      settle();
      chk("t2_ack", 32'(in_ack), 1);
      chk("t2_accept_stall", 32'(stall), 1);
      adv();
      in_valid = '0;
      settle();
      chk("t2_exec_en", 32'(exec_en), 1);
      chk("t2_stall_cnt", 32'(stall_cnt), 5);
      adv();

      // MOV ANY->ANY: RIGHT wins the read, RIGHT wins the write.
      in_valid = 4'b1010;
      issue(1, 7, 7);
      settle();
      chk("t3_ack", 32'(in_ack), 2);
      chk("t3_rd_port_sel", 32'(port_sel), 1);
      adv();
      in_valid = '0;
      settle();
      chk("t3_out_valid_wait", 32'(out_valid), 15);
      adv();
      out_ready = 4'b0110;
      settle();
      chk("t3_out_valid_accept", 32'(out_valid), 15);
      chk("t3_wr_port_sel", 32'(port_sel), 1);
      adv();
      out_ready = '0;
      settle();
      chk("t3_out_valid_drop", 32'(out_valid), 0);
      chk("t3_exec_en", 32'(exec_en), 1);
      adv();

      // Reset while waiting to write, with the neighbour ready in that cycle.
      issue(1, 1, 5);
      settle();
      chk("t4_out_valid", 32'(out_valid), 4);
      adv();
      reset = 1'b1;
      out_ready = 4'b0100;
      settle();
      chk("t4_valid_in_reset", 32'(out_valid), 0);
      adv();
      reset = 1'b0;
      out_ready = '0;
      settle();
      chk("t4_exec_en", 32'(exec_en), 0);
      chk("t4_stall", 32'(stall), 0);
      chk("t4_stall_cnt", 32'(stall_cnt), 0);
      chk("t4_port_sel", 32'(port_sel), 0);
      chk("t4_state", 32'(dbg_state), 0);
      adv();

      // SWP, SAV, JGZ decode.
      issue(2, 0, 0);
      settle();
      chk("t5_swp_SwpinB", 32'(swpin_b), 1);
      chk("t5_swp_enBak", 32'(en_bak), 1);
      chk("t5_swp_SwpActiveReg", 32'(swp_active), 1);
      adv();
      issue(3, 0, 0);
      settle();
      chk("t5_sav_SwpinB", 32'(swpin_b), 1);
      chk("t5_sav_enBak", 32'(en_bak), 1);
      chk("t5_sav_SwpActiveReg", 32'(swp_active), 0);
      adv();
      issue(10, 0, 0);
      settle();
      chk("t5_jgz_jmpInstr", 32'(jmp), 1);
      chk("t5_jgz_jmpCond", 32'(jcond), 2);
      chk("t5_jgz_exec_en", 32'(exec_en), 1);
      adv();

`ifdef NODE_EXEC_CTRL_DEADLOCK_EN
      // MOV ACC->DOWN with DOWN never ready: flag after 255 stall cycles.
      issue(1, 1, 5);
      for (int i = 1; i <= 256; i++) begin
         settle();
         if (i == 255) chk("t6_deadlock_before", 32'(deadlock), 0);
         if (i == 256) chk("t6_deadlock_set", 32'(deadlock), 1);
         adv();
      end
      out_ready = 4'b0100;
      cyc();
      out_ready = '0;
      settle();
      chk("t6_exec_en", 32'(exec_en), 1);
      chk("t6_deadlock_sticky", 32'(deadlock), 1);
      adv();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      settle();
      chk("t6_deadlock_cleared", 32'(deadlock), 0);
      adv();
`endif

      // Randomized instructions and neighbour behaviour.
      for (int n = 0; n < 4000; n++) begin
         reset     = ($urandom_range(0, 299) == 0);
         run       = ($urandom_range(0, 3) != 0);
         instr     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(14, 31))
                                                 : 5'($urandom_range(0, 13));
         src       = 3'($urandom_range(0, 7));
         dst       = 3'($urandom_range(0, 7));
         in_valid  = 4'($urandom) & 4'($urandom);
         out_ready = 4'($urandom) & 4'($urandom);
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/node_exec_ctrl.md
Name: node_exec_ctrl

Overview:
- Per-node sequencer for the TIS-100 execution path.
- Decodes the current instruction's type and operand selectors into the data_path/jmp_path control signals.
- Blocks on neighbour-port reads and writes using valid/ready handshakes, arbitrating ANY source/destination across the four ports.
- Issues a single-cycle commit strobe that advances ACC/BAK and the PC.

Parameters:
NUM_PORTS, 4, neighbour ports (UP, RIGHT, DOWN, LEFT = index 0..3)
STALL_W, 16, width of saturating stall counter
DEADLOCK_CYCLES, 255, stall cycles before deadlock flag (optional feature only)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  permit starting the next instruction
instrType  in  5  instruction type code
src_sel  in  3  source: 0 NIL, 1 ACC, 2 IMM, 3 UP, 4 RIGHT, 5 DOWN, 6 LEFT, 7 ANY
dst_sel  in  3  destination, same codes; IMM treated as NIL
port_in_valid  in  4  neighbour has data for us
port_in_ack  out  4  one-hot read accept; also the data_path read-latch strobe
port_out_ready  in  4  neighbour accepts our data
port_out_valid  out  4  write offer
port_sel  out  2  port index won by the current read/write
SwpActiveReg  out  1  1 = SWP, 0 = SAV
SwpinA  out  2  operand select: 00 ACC, 01 IMM, 10 port, 11 NIL
SwpinB  out  1  BAK-access instruction (SWP/SAV)
enBak  out  1  BAK write enable
ALUdesk  out  2  00 pass, 01 ADD, 10 SUB, 11 NEG
jmpInstr  out  1  jump-class instruction
jmpCond  out  2  00 EZ, 01 NZ, 10 GZ, 11 LZ; 00 for JMP/JRO
exec_en  out  1  one-cycle commit strobe to data_path/jmp_path
stall  out  1  high in any wait state
stall_cnt  out  STALL_W  saturating count of stall cycles
deadlock  out  1  sticky deadlock flag

Behaviour:
- Reset: synchronous, active-high, exactly as decided (one clock `clk`, reset `reset`).
  - State goes to DECODE.
  - All outputs are 0, including stall_cnt and deadlock.
  - Reset mid-wait drops valid/ack in the same cycle and suppresses exec_en.
- FSM states: DECODE, RD_WAIT, WR_WAIT, COMMIT.
- DECODE:
  - If run=0: hold.
  - Else register the decoded controls, which stay stable until exec_en.
  - Next state: RD_WAIT if the source is a port/ANY (MOV, ADD, SUB, JRO); else WR_WAIT if MOV and the destination is a port/ANY; else COMMIT.
- RD_WAIT:
  - Port source: wait for the selected port_in_valid.
  - ANY source: fixed priority UP > RIGHT > DOWN > LEFT among the valid ports.
  - In the accept cycle, port_in_ack is Mealy one-hot and port_sel holds the winner.
  - Next state: WR_WAIT if MOV to a port, else COMMIT.
- WR_WAIT:
  - port_out_valid is high on the selected port (all four for ANY) until a ready arrives.
  - Winner is the lowest-index ready port; port_sel is updated.
  - All valids drop the next cycle → COMMIT.
  - Simultaneous readies count only the winner.
- COMMIT: exec_en=1 for one cycle → DECODE.
- Latency (DECODE to exec_en):
  - 2 cycles with no port operand.
  - 3 cycles for a port read with valid already high.
  - Port-to-port MOV with neighbours ready: 4 cycles.
- NIL source/destination never waits.
- A read and a write are never in flight simultaneously.
- Decode:
  - SWP: SwpinB=1, SwpActiveReg=1, enBak=1.
  - SAV: SwpinB=1, SwpActiveReg=0, enBak=1.
  - ADD/SUB/NEG set ALUdesk.
  - Jump types set jmpInstr=1 and jmpCond.
  - HCF and undefined codes decode as NOP.
- stall_cnt:
  - Increments each RD_WAIT/WR_WAIT cycle; saturates at all-ones.
  - Cleared only by reset.

Optional Feature:
- Macro NODE_EXEC_CTRL_DEADLOCK_EN.
- Defined:
  - An 8-bit wait-run counter resets on every state change out of a wait state.
  - When it reaches DEADLOCK_CYCLES, deadlock sets sticky until reset.
  - The FSM keeps waiting.
- Undefined: counter absent; deadlock tied 0.

Decomposition:
- Package tis_ctrl_pkg:
  - instrType codes: 0 NOP, 1 MOV, 2 SWP, 3 SAV, 4 ADD, 5 SUB, 6 NEG, 7 JMP, 8 JEZ, 9 JNZ, 10 JGZ, 11 JLZ, 12 JRO, 13 HCF.
  - src/dst codes, FSM state enum, ALUdesk/jmpCond/SwpinA encodings.
- One sub-module: port_prio_arb (4-bit request → one-hot grant + 2-bit index, UP-highest), shared by RD_WAIT and WR_WAIT.

Test Plan:
1. ADD IMM (type 4, src 2) with run=1 → ALUdesk=01, SwpinA=01; exec_en exactly 2 cycles after DECODE; stall never high.
2. MOV UP→ACC, port_in_valid[0] raised after 5 cycles → stall=1 for 5 cycles, stall_cnt=5; port_in_ack=0001 for one cycle; exec_en on the next cycle.
3. MOV ANY→ANY, port_in_valid=1010 then port_out_ready=0110:
   - ack=0010 (RIGHT), port_sel=1.
   - Then port_out_valid=1111 until ready; winner RIGHT, port_sel=1; valid=0000 the next cycle.
4. Reset asserted in WR_WAIT → next cycle all outputs 0, state DECODE, no exec_en.
5. SWP then SAV (run=1) → SwpinB=1, enBak=1 on both; SwpActiveReg 1 then 0; JGZ gives jmpInstr=1, jmpCond=10.
6. With NODE_EXEC_CTRL_DEADLOCK_EN, DEADLOCK_CYCLES=255, MOV ACC→DOWN, out_ready held 0 → deadlock=1 after 255 stall cycles; it stays 1 after ready arrives, until reset.
